vga_tile_renderer: RTL and testbench
====================================

// Module: vga_tile_renderer
// PURPOSE
//  Downstream consumer of the block-info RAM: generates 640x480@60 VGA timing and converts each visible
//  pixel to a grid tile address. Reads that tile's 32-bit info word and outputs 12-bit RGB with sync.
//  Sits between the board RAM (read port) and the VGA connector.
//  Game logic writes the RAM during vblank, qualified by frame_start/vblank.
// PARAMETERS
//  DATA_WIDTH     32    RAM word width; only bits [7:0] are decoded
//  ADDRESS_WIDTH  12    RAM address width
//  GRID_COLS      5     tiles per row
//  GRID_ROWS      5     tiles per column
//  TILE_PX        64    tile edge in pixels (power of two)
//  ORIGIN_X       160   left pixel column of the grid
//  ORIGIN_Y       80    top pixel row of the grid
//  PIX_DIV        4     clk cycles per pixel (>=3)
// PORTS
//  clk          in   1              system clock; all logic on posedge
//  reset        in   1              asynchronous, active-high
//  ram_addr     out  ADDRESS_WIDTH  tile address to RAM read port
//  ram_data     in   DATA_WIDTH     RAM dataOut (RAM samples addr on negedge clk)
//  hsync        out  1              active-low horizontal sync
//  vsync        out  1              active-low vertical sync
//  rgb          out  12             {R[3:0],G[3:0],B[3:0]}; 0 outside the active area
//  vblank       out  1              high while line counter >= 480
//  frame_start  out  1              one-clk pulse when line 480 pixel 0 begins
//  cursor_idx   in   ADDRESS_WIDTH  selected tile (only with CURSOR_HILITE_EN)
// BEHAVIOUR
//  Reset: div/hcnt/vcnt=0, ram_addr=0, hsync=vsync=1, rgb=0, vblank=0, frame_start=0. Reset mid-frame
//   restarts at pixel (0,0); first hsync falls 656 pixels after release.
//  Tick: div counts 0..PIX_DIV-1; tick=(div==PIX_DIV-1). hcnt 0..799 advances on tick. At 799 it wraps
//   to 0 and vcnt increments (0..524, wraps to 0).
//  Timing: hsync low for hcnt 656..751; vsync low for vcnt 490..491; active = hcnt<640 && vcnt<480.
//  Pipeline (clk cycles after tick edge T0 that loads new hcnt/vcnt):
//   T1: ram_addr <= row*GRID_COLS+col, where col=(hcnt-ORIGIN_X)/TILE_PX and row=(vcnt-ORIGIN_Y)/TILE_PX.
//       Shifts only. Outside grid, ram_addr holds its value. in_grid/offset/sync/active staged.
//   T1 negedge: RAM returns ram_data.
//   T2: rgb, hsync, vsync registered together; total latency 2 clk, aligned, stable until next T2.
//  Decode (in_grid): bit0 revealed, bit1 mine, bit2 flagged, bits[7:4] count.
//   Grid line: x or y offset==0 -> 12'h000.
//   Not revealed and flagged -> 12'hF80. Not revealed, not flagged -> 12'h888.
//   Revealed and mine -> 12'hF00. Revealed, no mine -> COUNT_PAL[count]; count>8 -> 12'hF0F.
//  Active and outside grid -> 12'h222; inactive -> 12'h000.
//  frame_start: asserted the clk after tick loads hcnt=0,vcnt=480. vblank registered from vcnt.
//  Renderer never drives wEn; writes by others during active video may show one stale pixel only.
// CONFIGURATION
//  CURSOR_HILITE_EN defined: cursor_idx port exists. Pixels of tile cursor_idx with x or y offset in
//   {1,2,TILE_PX-2,TILE_PX-1} output 12'hFF0, overriding the decode above.
//  Undefined: port absent; no highlight logic.
// STRUCTURE
//  Package minesweeper_pkg: field bit positions (REVEALED_BIT, MINE_BIT, FLAG_BIT, COUNT_LSB/MSB),
//   COUNT_PAL[0:8] colour table, named colour constants, VGA timing constants (H_VIS 640, H_FP 16,
//   H_SYNC 96, H_BP 48, V_VIS 480, V_FP 10, V_SYNC 2, V_BP 33).
//  Sub-module vga_timing: divider + hcnt/vcnt + raw sync/active/vblank/frame_start.
//  This module adds the address pipeline and colour decode.
// TESTING
//  1. Reset mid-line, release -> hsync=1; first hsync low at pixel 656 lasting 96*PIX_DIV clks; vsync
//     low lines 490-491; frame period 800*525*PIX_DIV clks.
//  2. Addressing: pixel (160,80)->addr 0; (224,80)->1; (160,144)->5; (479,399)->24. Check each with
//     ram_data from a behavioural negedge RAM; (159,80) -> rgb 12'h222, addr unchanged.
//  3. Decode: preload words 0x0, 0x4, 0x3, 0x31, 0x91 -> rgb 888, F80, F00, COUNT_PAL[3], F0F
//     at tile interior pixels; tile offset 0 pixels -> 000.
//  4. Latency: rgb/hsync/vsync change exactly 2 clk after the tick edge; all three change in the same cycle.
//  5. frame_start exactly one clk per frame at line 480; vblank high lines 480-524; write during
//     vblank alters next frame's colour only.
//  6. With CURSOR_HILITE_EN, cursor_idx=12: tile 12 border pixels offset 1 -> FF0; offset 3 -> decoded
//     colour. Without macro: build without the port and compare identically to step 3.

Source files
------------

// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper board display: tile-word field positions,
// colour constants, count palette and 640x480@60 VGA timing.
package minesweeper_pkg;

  localparam int REVEALED_BIT = 0;
  localparam int MINE_BIT     = 1;
  localparam int FLAG_BIT     = 2;
  localparam int COUNT_LSB    = 4;
  localparam int COUNT_MSB    = 7;

  typedef logic [11:0] rgb_t;

  localparam rgb_t C_BLACK      = 12'h000;
  localparam rgb_t C_HIDDEN     = 12'h888;
  localparam rgb_t C_FLAG       = 12'hF80;
  localparam rgb_t C_MINE       = 12'hF00;
  localparam rgb_t C_BAD_COUNT  = 12'hF0F;
  localparam rgb_t C_BACKGROUND = 12'h222;
  localparam rgb_t C_CURSOR     = 12'hFF0;

  localparam rgb_t COUNT_PAL [0:8] = '{
    12'hCCC, 12'h00F, 12'h0A0, 12'hD00, 12'h008,
    12'h800, 12'h088, 12'h444, 12'hAAA
  };

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  // Counts above 8 cannot occur on a real board, so they get a loud marker colour.
  function automatic rgb_t count_colour(input logic [3:0] cnt);
    if (cnt > 4'd8) return C_BAD_COUNT;
    return COUNT_PAL[cnt];
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster generator: pixel-clock divider, horizontal/vertical counters and the
// raw sync/active levels plus registered vblank and frame_start.
module vga_timing
  import minesweeper_pkg::*;
#(
  parameter int PIX_DIV   = 4,
  parameter int H_VISIBLE = minesweeper_pkg::H_VIS,
  parameter int H_FRONT   = minesweeper_pkg::H_FP,
  parameter int H_SYNC_W  = minesweeper_pkg::H_SYNC,
  parameter int H_BACK    = minesweeper_pkg::H_BP,
  parameter int V_VISIBLE = minesweeper_pkg::V_VIS,
  parameter int V_FRONT   = minesweeper_pkg::V_FP,
  parameter int V_SYNC_W  = minesweeper_pkg::V_SYNC,
  parameter int V_BACK    = minesweeper_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       o_pix_new,
  output logic [9:0] o_hcnt,
  output logic [9:0] o_vcnt,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_active,
  output logic       o_vblank,
  output logic       o_frame_start
);
  localparam int DIV_W    = $clog2(PIX_DIV);
  localparam int H_TOT    = H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK;
  localparam int V_TOT    = V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int VS_START = V_VISIBLE + V_FRONT;

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_hcnt;
  logic [9:0]       r_vcnt;
  logic             r_vblank;
  logic             r_frame_start;
  logic             w_tick;

  assign w_tick    = (r_div == DIV_W'(PIX_DIV - 1));
  // First clk of a pixel: the counters were loaded on the previous edge.
  assign o_pix_new = (r_div == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div         <= '0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_vblank      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) begin
        if (r_hcnt == 10'(H_TOT - 1)) begin
          r_hcnt <= '0;
          r_vcnt <= (r_vcnt == 10'(V_TOT - 1)) ? '0 : r_vcnt + 10'd1;
        end else begin
          r_hcnt <= r_hcnt + 10'd1;
        end
      end
      r_vblank      <= (r_vcnt >= 10'(V_VISIBLE));
      r_frame_start <= o_pix_new && (r_hcnt == '0) && (r_vcnt == 10'(V_VISIBLE));
    end
  end

  assign o_hcnt        = r_hcnt;
  assign o_vcnt        = r_vcnt;
  assign o_hsync       = !((r_hcnt >= 10'(HS_START)) && (r_hcnt < 10'(HS_START + H_SYNC_W)));
  assign o_vsync       = !((r_vcnt >= 10'(VS_START)) && (r_vcnt < 10'(VS_START + V_SYNC_W)));
  assign o_active      = (r_hcnt < 10'(H_VISIBLE)) && (r_vcnt < 10'(V_VISIBLE));
  assign o_vblank      = r_vblank;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_tile_renderer.sv
// Minesweeper board renderer: maps each visible pixel to a tile address, decodes the
// tile word into 12-bit RGB. Define CURSOR_HILITE_EN to add cursor_idx and its highlight ring.
module vga_tile_renderer
  import minesweeper_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int GRID_COLS     = 5,
  parameter int GRID_ROWS     = 5,
  parameter int TILE_PX       = 64,
  parameter int ORIGIN_X      = 160,
  parameter int ORIGIN_Y      = 80,
  parameter int PIX_DIV       = 4,
  parameter int H_VISIBLE     = minesweeper_pkg::H_VIS,
  parameter int H_FRONT       = minesweeper_pkg::H_FP,
  parameter int H_SYNC_W      = minesweeper_pkg::H_SYNC,
  parameter int H_BACK        = minesweeper_pkg::H_BP,
  parameter int V_VISIBLE     = minesweeper_pkg::V_VIS,
  parameter int V_FRONT       = minesweeper_pkg::V_FP,
  parameter int V_SYNC_W      = minesweeper_pkg::V_SYNC,
  parameter int V_BACK        = minesweeper_pkg::V_BP
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_data,
  output logic                     hsync,
  output logic                     vsync,
  output logic [11:0]              rgb,
  output logic                     vblank,
  output logic                     frame_start
`ifdef CURSOR_HILITE_EN
  ,
  input  logic [ADDRESS_WIDTH-1:0] cursor_idx
`endif
);
  localparam int TW     = $clog2(TILE_PX);
  localparam int GRID_W = GRID_COLS * TILE_PX;
  localparam int GRID_H = GRID_ROWS * TILE_PX;

  logic                     w_pix_new;
  logic [9:0]               w_hcnt;
  logic [9:0]               w_vcnt;
  logic [9:0]               w_gx;
  logic [9:0]               w_gy;
  logic                     w_hsync;
  logic                     w_vsync;
  logic                     w_active;
  logic                     w_in_grid;
  logic                     w_on_line;
  logic [ADDRESS_WIDTH-1:0] w_tile;
  logic [11:0]              w_colour;
  logic                     w_unused;

  logic r_vld_p1;
  logic r_active_p1;
  logic r_in_grid_p1;
  logic r_line_p1;
  logic r_hsync_p1;
  logic r_vsync_p1;
`ifdef CURSOR_HILITE_EN
  logic r_cursor_p1;

  function automatic logic ring_hit(input logic [TW-1:0] off);
    return (off == TW'(1)) || (off == TW'(2)) ||
           (off == TW'(TILE_PX - 2)) || (off == TW'(TILE_PX - 1));
  endfunction
`endif

  function automatic logic [11:0] decode_tile(input logic revealed, input logic mine,
                                              input logic flagged, input logic [3:0] count);
    if (!revealed) return flagged ? C_FLAG : C_HIDDEN;
    if (mine) return C_MINE;
    return count_colour(count);
  endfunction

  vga_timing #(
    .PIX_DIV  (PIX_DIV),
    .H_VISIBLE(H_VISIBLE),
    .H_FRONT  (H_FRONT),
    .H_SYNC_W (H_SYNC_W),
    .H_BACK   (H_BACK),
    .V_VISIBLE(V_VISIBLE),
    .V_FRONT  (V_FRONT),
    .V_SYNC_W (V_SYNC_W),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .o_pix_new    (w_pix_new),
    .o_hcnt       (w_hcnt),
    .o_vcnt       (w_vcnt),
    .o_hsync      (w_hsync),
    .o_vsync      (w_vsync),
    .o_active     (w_active),
    .o_vblank     (vblank),
    .o_frame_start(frame_start)
  );

  // ---- stage p1: tile address to RAM, pixel attributes staged alongside ----
  assign w_gx      = w_hcnt - 10'(ORIGIN_X);
  assign w_gy      = w_vcnt - 10'(ORIGIN_Y);
  assign w_in_grid = (w_hcnt >= 10'(ORIGIN_X)) && (w_hcnt < 10'(ORIGIN_X + GRID_W)) &&
                     (w_vcnt >= 10'(ORIGIN_Y)) && (w_vcnt < 10'(ORIGIN_Y + GRID_H));
  assign w_tile    = ADDRESS_WIDTH'(w_gy[9:TW]) * ADDRESS_WIDTH'(GRID_COLS) +
                     ADDRESS_WIDTH'(w_gx[9:TW]);
  assign w_on_line = (w_gx[TW-1:0] == '0) || (w_gy[TW-1:0] == '0);
  assign w_unused  = ^{ram_data[DATA_WIDTH-1:8], ram_data[3]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_pix_new;
      if (w_pix_new && w_in_grid) ram_addr <= w_tile;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pix_new) begin
      r_active_p1  <= w_active;
      r_in_grid_p1 <= w_in_grid;
      r_line_p1    <= w_on_line;
      r_hsync_p1   <= w_hsync;
      r_vsync_p1   <= w_vsync;
`ifdef CURSOR_HILITE_EN
      r_cursor_p1  <= (w_tile == cursor_idx) && (ring_hit(w_gx[TW-1:0]) || ring_hit(w_gy[TW-1:0]));
`endif
    end
  end

  // ---- stage p2: RAM word arrived on the p1 negedge; colour and sync leave together ----
  always_comb begin
    w_colour = C_BLACK;
    if (r_active_p1) begin
      if (!r_in_grid_p1) begin
        w_colour = C_BACKGROUND;
      end else if (!r_line_p1) begin
        w_colour = decode_tile(ram_data[REVEALED_BIT], ram_data[MINE_BIT], ram_data[FLAG_BIT],
                               ram_data[COUNT_MSB:COUNT_LSB]);
      end
`ifdef CURSOR_HILITE_EN
      if (r_in_grid_p1 && r_cursor_p1) w_colour = C_CURSOR;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (r_vld_p1) begin
      rgb   <= w_colour;
      hsync <= r_hsync_p1;
      vsync <= r_vsync_p1;
    end
  end

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Bench for vga_tile_renderer on a shrunken raster; every cycle is compared against a
// pixel-index model of the raster. Honours CURSOR_HILITE_EN like the design.
module tb_vga_tile_renderer;
  import minesweeper_pkg::*;

  localparam int P = 3, T = 8, COLS = 5, ROWS = 5, OX = 8, OY = 4;
  localparam int HV = 56, HF = 4, HS = 6, HB = 6;
  localparam int VV = 50, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT * P;
  localparam int CUR_TILE = 12;
`ifdef CURSOR_HILITE_EN
  localparam int CUR_RGB = 'hFF0;
`else
  localparam int CUR_RGB = 'hF80;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] ram_addr;
  logic [31:0] ram_data = '0;
  logic        hsync, vsync, vblank, frame_start;
  logic [11:0] rgb;
  logic [11:0] cursor_idx = 12'(CUR_TILE);
  logic [31:0] mem [0:31];

  int checks = 0;
  int failures = 0;
  int k = 0;
  int exp_addr = 0;
  int prev_hs = 1, seen_fall = 0, fall_k = -1, last_fs = -1;

  int lit_h   [14] = '{9, 17, 25, 33, 41, 8, 7, 9, 47, 25, 27, 11, 50, 60};
  int lit_v   [14] = '{5, 5, 5, 5, 5, 5, 5, 13, 43, 21, 23, 7, 20, 20};
  int lit_rgb [14] = '{'h888, 'hF80, 'hF00, int'(COUNT_PAL[3]), 'hF0F, 'h000, 'h222,
                       'hF80, 'hF00, CUR_RGB, 'hF80, 'h888, 'h222, 'h000};
  int lit_adr [14] = '{0, 1, 2, 3, 4, 0, 4, 5, 24, 12, 12, 0, -1, -1};

  vga_tile_renderer #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(12), .GRID_COLS(COLS), .GRID_ROWS(ROWS),
    .TILE_PX(T), .ORIGIN_X(OX), .ORIGIN_Y(OY), .PIX_DIV(P),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC_W(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC_W(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .ram_addr(ram_addr), .ram_data(ram_data),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .vblank(vblank), .frame_start(frame_start)
`ifdef CURSOR_HILITE_EN
    , .cursor_idx(cursor_idx)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) ram_data <= (ram_addr < 12'd32) ? mem[ram_addr[4:0]] : 32'h0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (clk %0d after release)", name, act, exp, k);
    end
  endtask

  function automatic bit in_grid(int h, int v);
    return h >= OX && h < OX + COLS * T && v >= OY && v < OY + ROWS * T;
  endfunction

  function automatic int tile_of(int h, int v);
    return ((v - OY) / T) * COLS + (h - OX) / T;
  endfunction

  function automatic int model_rgb(int h, int v);
    int ox, oy;
    logic [31:0] w;
    logic [3:0] cnt;
    if (h >= HV || v >= VV) return 0;
    if (!in_grid(h, v)) return 'h222;
    ox = (h - OX) % T;
    oy = (v - OY) % T;
`ifdef CURSOR_HILITE_EN
    if (tile_of(h, v) == CUR_TILE && (ox inside {1, 2, T - 2, T - 1} || oy inside {1, 2, T - 2, T - 1}))
      return 'hFF0;
`endif
    if (ox == 0 || oy == 0) return 0;
    w = mem[tile_of(h, v)];
    if (!w[0]) return w[2] ? 'hF80 : 'h888;
    if (w[1]) return 'hF00;
    cnt = w[7:4];
    if (cnt > 4'd8) return 'hF0F;
    return int'(COUNT_PAL[cnt]);
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    return w;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 32; i++)
      if (!(i inside {0, 1, 2, 3, 4, 5, 12, 24})) mem[i] = rand_word();
  endtask

  task automatic check_reset_state();
    check("reset_ram_addr", int'(ram_addr), 0);
    check("reset_rgb", int'(rgb), 0);
    check("reset_hsync", int'(hsync), 1);
    check("reset_vsync", int'(vsync), 1);
    check("reset_vblank", int'(vblank), 0);
    check("reset_frame_start", int'(frame_start), 0);
  endtask

  task automatic compare_cycle();
    int m, h, v, h1, v1, e_rgb, e_hs, e_vs;
    e_rgb = 0; e_hs = 1; e_vs = 1; h = -1; v = -1;
    if (k >= 2) begin
      m = (k - 2) / P;
      h = m % HT;
      v = (m / HT) % VT;
      e_rgb = model_rgb(h, v);
      e_hs = (h >= HV + HF && h < HV + HF + HS) ? 0 : 1;
      e_vs = (v >= VV + VF && v < VV + VF + VS) ? 0 : 1;
    end
    check("rgb", int'(rgb), e_rgb);
    check("hsync", int'(hsync), e_hs);
    check("vsync", int'(vsync), e_vs);
    m = (k - 1) / P;
    h1 = m % HT;
    v1 = (m / HT) % VT;
    if ((k - 1) % P == 0 && in_grid(h1, v1)) exp_addr = tile_of(h1, v1);
    check("ram_addr", int'(ram_addr), exp_addr);
    check("vblank", int'(vblank), (v1 >= VV) ? 1 : 0);
    check("frame_start", int'(frame_start), ((k - 1) % P == 0 && h1 == 0 && v1 == VV) ? 1 : 0);
    for (int i = 0; i < 14; i++) begin
      if (k >= 2 && (k - 2) % P == 0 && h == lit_h[i] && v == lit_v[i])
        check($sformatf("lit_rgb_%0d_%0d", lit_h[i], lit_v[i]), int'(rgb), lit_rgb[i]);
      if ((k - 1) % P == 0 && h1 == lit_h[i] && v1 == lit_v[i] && lit_adr[i] >= 0)
        check($sformatf("lit_addr_%0d_%0d", lit_h[i], lit_v[i]), int'(ram_addr), lit_adr[i]);
    end
    if (prev_hs == 1 && hsync == 1'b0) begin
      if (seen_fall == 0) begin
        check("first_hsync_fall_clk", k, (HV + HF) * P + 2);
        seen_fall = 1;
      end
      fall_k = k;
    end
    if (prev_hs == 0 && hsync == 1'b1 && fall_k >= 0) check("hsync_low_clks", k - fall_k, HS * P);
    prev_hs = int'(hsync);
    if (frame_start) begin
      if (last_fs >= 0) check("frame_period_clks", k - last_fs, FRAME);
      last_fs = k;
    end
    if ((k - 1) % P == 0 && h1 == 0 && v1 == VV + 1) fill_random();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      #1;
      compare_cycle();
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    exp_addr = 0;
    prev_hs = 1; seen_fall = 0; fall_k = -1; last_fs = -1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = rand_word();
    mem[0] = 32'h0;  mem[1] = 32'h4;  mem[2] = 32'h3;   mem[3] = 32'h31;
    mem[4] = 32'h91; mem[5] = 32'h4;  mem[12] = 32'h4;  mem[24] = 32'h3;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    release_reset();
    run(2 * FRAME + $urandom_range(HT * P * 5, HT * P * 30));
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_state();
    repeat (2) @(posedge clk);
    release_reset();
    run(FRAME + 200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
